// File: rtl/updown_counter_mod.sv
// updown_counter_mod
//   Up/down counter with modulo (MAX_VAL+1) arithmetic and a per-edge choice
//   between wrapping and saturating at the bounds. The count step is
//   programmable and clamped to MAX_VAL.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   rst       : asynchronous active-high reset (count=0, ovf_p=0)
//   en        : count enable
//   ctrl      : direction, 1 = up, 0 = down
//   sat       : boundary mode, 1 = saturate, 0 = wrap
//   load      : synchronous load strobe (beats en)
//   load_val  : value to load, clamped to MAX_VAL
//   step      : increment/decrement magnitude, clamped to MAX_VAL
//   count     : registered count value, always <= MAX_VAL
//   at_max    : count == MAX_VAL
//   at_min    : count == 0
//   ovf_p     : registered one-cycle pulse after an update that crossed a bound
module updown_counter_mod #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_p
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH:0]   up_sum;
  logic             cross_up;
  logic             cross_dn;

  always_comb begin
    step_eff = (step > MAX_VAL) ? MAX_VAL : step;
    load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    // Carry bit is needed only to detect the up crossing.
    up_sum   = {1'b0, count_q} + {1'b0, step_eff};
    cross_up = (up_sum > {1'b0, MAX_VAL});
    cross_dn = (step_eff > count_q);
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = load_eff;
    end else if (en && (step_eff != '0)) begin
      if (ctrl) begin
        if (cross_up) begin
          ovf_d = 1'b1;
          // The wrapped result is < 2**WIDTH, so modular WIDTH-bit math
          // gives raw - (MAX_VAL+1) exactly.
          count_d = sat ? MAX_VAL : (count_q + step_eff - MAX_VAL - ONE);
        end else begin
          count_d = count_q + step_eff;
        end
      end else begin
        if (cross_dn) begin
          ovf_d = 1'b1;
          // (MAX_VAL+1) - (step_eff - count) rearranged to stay in WIDTH bits.
          count_d = sat ? '0 : (MAX_VAL - step_eff + count_q + ONE);
        end else begin
          count_d = count_q - step_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count  = count_q;
  assign ovf_p  = ovf_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod with WIDTH=4, MAX_VAL=9.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ctrl;
  logic       sat;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] step;
  logic [3:0] count;
  logic       at_max;
  logic       at_min;
  logic       ovf_p;

  int unsigned total  = 0;
  int unsigned passed = 0;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ctrl     (ctrl),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .count    (count),
    .at_max   (at_max),
    .at_min   (at_min),
    .ovf_p    (ovf_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count, at_max, at_min, ovf_p in one go
  task automatic chk_all(input string tag, input int c, input int mx, input int mn, input int o);
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".at_max"}, 32'(at_max), 32'(mx));
    check({tag, ".at_min"}, 32'(at_min), 32'(mn));
    check({tag, ".ovf_p"},  32'(ovf_p),  32'(o));
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ctrl = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0; step = '0;
    #3;
    chk_all("reset_init", 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges
    do_load(4'd7);
    chk_all("load7", 7, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 1, 0);
    // Load and update while in reset are ignored
    load = 1'b1; load_val = 4'd5; en = 1'b1; step = 4'd1;
    tick();
    chk_all("rst_hold", 0, 0, 1, 0);
    load = 1'b0; en = 1'b0; rst = 1'b0;

    // Up wrap
    do_load(4'd8);
    en = 1'b1; ctrl = 1'b1; sat = 1'b0; step = 4'd1;
    tick(); chk_all("upwrap_9", 9, 1, 0, 0);
    tick(); chk_all("upwrap_0", 0, 0, 1, 1);
    tick(); chk_all("upwrap_1", 1, 0, 0, 0);

    // Down wrap
    en = 1'b0;
    do_load(4'd1);
    en = 1'b1; ctrl = 1'b0; step = 4'd3;
    tick(); chk_all("dnwrap_8", 8, 0, 0, 1);
    do_load(4'd5);
    chk_all("load5", 5, 0, 0, 0);
    step = 4'd12;
    tick(); chk_all("dnwrap_clamp", 6, 0, 0, 1);

    // Saturate
    en = 1'b0;
    do_load(4'd2);
    en = 1'b1; ctrl = 1'b0; sat = 1'b1; step = 4'd3;
    tick(); chk_all("sat_dn", 0, 0, 1, 1);
    tick(); chk_all("sat_dn_pinned", 0, 0, 1, 1);
    ctrl = 1'b1; step = 4'd4;
    tick(); chk_all("sat_up4", 4, 0, 0, 0);
    en = 1'b0;
    do_load(4'd7);
    en = 1'b1;
    tick(); chk_all("sat_up_cross", 9, 1, 0, 1);

    // Load priority and clamp; also clears the pending pulse
    load = 1'b1; load_val = 4'd12;
    tick(); chk_all("load_clamp", 9, 1, 0, 0);
    load = 1'b0;
    do_load(4'd5);
    step = 4'd4;
    tick(); chk_all("sat_exact_max", 9, 1, 0, 0);

    // Hold with en=0, after a pinned overflow pulse
    step = 4'd1;
    tick(); chk_all("sat_up_pinned", 9, 1, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("hold_en0", 9, 1, 0, 0);
    end
    en = 1'b1; step = 4'd0;
    tick(); chk_all("hold_step0", 9, 1, 0, 0);

    // Exact reach of the bounds is not a crossing; clamped up wrap
    sat = 1'b0; ctrl = 1'b0; step = 4'd9;
    tick(); chk_all("dn_exact_0", 0, 0, 1, 0);
    ctrl = 1'b1; step = 4'd15;
    tick(); chk_all("up_clamp_9", 9, 1, 0, 0);
    tick(); chk_all("up_wrap_8", 8, 0, 0, 1);
    // Direction change takes effect on the same edge
    ctrl = 1'b0; step = 4'd2;
    tick(); chk_all("dir_change", 6, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
